// File: rtl/parity_pkg.sv
// Shared types and helpers for the framed parity accumulator.
// Used by the RTL and by its testbenches.
package parity_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int cnt_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/parity_reduce.sv
// XOR reduction of one data word.
// Generalises the old fixed 3-input parity cell.
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_stream.sv
// Accumulates parity over a valid/ready framed stream and
// emits one registered {parity, count, err} result per frame.
module parity_stream
  import parity_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 16,
  localparam int CNT_W     = cnt_width(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             word_par;
  logic             accept, emit, close, first;
  logic             acc_inc, frame_mode;
  logic [CNT_W-1:0] cnt_inc;

  logic             ovalid_d, par_d, err_d;
  logic [CNT_W-1:0] ocnt_d;

  parity_reduce #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .data   (in_data),
    .parity (word_par)
  );

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    close      = 1'b0;
    ovalid_d   = out_valid;
    par_d      = out_parity;
    ocnt_d     = out_count;
    err_d      = out_err;

    // First word of a frame starts from a clean slate and sets the mode
    first      = (state_q == ST_IDLE);
    acc_inc    = (first ? 1'b0 : acc_q) ^ word_par;
    cnt_inc    = (first ? '0 : cnt_q) + CNT_W'(1);
    frame_mode = first ? in_odd : mode_q;

    if (accept) begin
      close  = in_last || (cnt_inc == CNT_W'(MAX_WORDS));
      mode_d = frame_mode;
      if (close) begin
        state_d = ST_IDLE;
        acc_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = ST_ACCUM;
        acc_d   = acc_inc;
        cnt_d   = cnt_inc;
      end
    end

    if (close) begin
      ovalid_d = 1'b1;
      par_d    = acc_inc ^ (frame_mode == PAR_ODD);
      ocnt_d   = cnt_inc;
      err_d    = !in_last;
    end else if (emit) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= PAR_EVEN;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      out_valid  <= ovalid_d;
      out_parity <= par_d;
      out_count  <= ocnt_d;
      out_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_parity_stream.sv
// Directed bench for parity_stream across three configurations:
// 3-bit single-word cell, 8-bit/16-word frames, 8-bit/4-word frames.
module tb_parity_stream;
  import parity_pkg::*;

  localparam int CW1  = cnt_width(1);
  localparam int CW16 = cnt_width(16);
  localparam int CW4  = cnt_width(4);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic            a_valid, a_ready, a_last, a_odd;
  logic            a_ovalid, a_oready, a_par, a_err;
  logic [2:0]      a_data;
  logic [CW1-1:0]  a_cnt;

  logic            b_valid, b_ready, b_last, b_odd;
  logic            b_ovalid, b_oready, b_par, b_err;
  logic [7:0]      b_data;
  logic [CW16-1:0] b_cnt;

  logic            c_valid, c_ready, c_last, c_odd;
  logic            c_ovalid, c_oready, c_par, c_err;
  logic [7:0]      c_data;
  logic [CW4-1:0]  c_cnt;

  parity_stream #(.WIDTH(3), .MAX_WORDS(1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_last(a_last), .in_odd(a_odd),
    .out_valid(a_ovalid), .out_ready(a_oready),
    .out_parity(a_par), .out_count(a_cnt), .out_err(a_err)
  );

  parity_stream #(.WIDTH(8), .MAX_WORDS(16)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_last(b_last), .in_odd(b_odd),
    .out_valid(b_ovalid), .out_ready(b_oready),
    .out_parity(b_par), .out_count(b_cnt), .out_err(b_err)
  );

  parity_stream #(.WIDTH(8), .MAX_WORDS(4)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
    .in_last(c_last), .in_odd(c_odd),
    .out_valid(c_ovalid), .out_ready(c_oready),
    .out_parity(c_par), .out_count(c_cnt), .out_err(c_err)
  );

  typedef struct packed {
    logic [2:0] data;
    logic       odd;
    logic       par;
  } vec_t;

  vec_t       tbl [16];
  logic [7:0] even_seq;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_word(input logic [7:0] d, input logic l, input logic o);
    b_valid = 1'b1; b_data = d; b_last = l; b_odd = o;
    tick();
  endtask

  task automatic c_word(input logic [7:0] d, input logic l, input logic o);
    c_valid = 1'b1; c_data = d; c_last = l; c_odd = o;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_valid = 0; a_data = '0; a_last = 0; a_odd = 0; a_oready = 0;
    b_valid = 0; b_data = '0; b_last = 0; b_odd = 0; b_oready = 0;
    c_valid = 0; c_data = '0; c_last = 0; c_odd = 0; c_oready = 0;

    // Even-mode parity of 0..7, bit i = parity of i (0,1,1,0,1,0,0,1)
    even_seq = 8'b1001_0110;
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{data: 3'(i), odd: 1'b0, par: even_seq[i]};
      tbl[i + 8] = '{data: 3'(i), odd: 1'b1, par: ~even_seq[i]};
    end

    // Reset state
    tick();
    tick();
    chk("rst_a_ovalid", a_ovalid, 0);
    chk("rst_b_ovalid", b_ovalid, 0);
    chk("rst_c_par", c_par, 0);
    chk("rst_c_cnt", c_cnt, 0);
    chk("rst_c_err", c_err, 0);
    chk("rst_b_ready", b_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_c_ready", c_ready, 1);

    // Table sweep on the 3-bit single-word configuration
    a_oready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1; a_data = tbl[i].data; a_last = 1'b1; a_odd = tbl[i].odd;
      #1;
      chk($sformatf("a_ready[%0d]", i), a_ready, 1);
      tick();
      chk($sformatf("a_ovalid[%0d]", i), a_ovalid, 1);
      chk($sformatf("a_par[%0d]", i), a_par, tbl[i].par);
      chk($sformatf("a_cnt[%0d]", i), a_cnt, 1);
      chk($sformatf("a_err[%0d]", i), a_err, 0);
    end
    // MAX_WORDS=1 without in_last: force-closed with err
    a_data = 3'b011; a_last = 1'b0; a_odd = 1'b0;
    tick();
    chk("a_nolast_err", a_err, 1);
    chk("a_nolast_par", a_par, 0);
    a_valid = 1'b0;
    tick();
    chk("a_drain", a_ovalid, 0);

    // 3-word frame FF,01,03 even
    b_oready = 1'b1;
    b_word(8'hFF, 1'b0, 1'b0);
    chk("b_mid1_ovalid", b_ovalid, 0);
    b_word(8'h01, 1'b0, 1'b0);
    chk("b_mid2_ovalid", b_ovalid, 0);
    b_word(8'h03, 1'b1, 1'b0);
    chk("b_f1_ovalid", b_ovalid, 1);
    chk("b_f1_par", b_par, 1);
    chk("b_f1_cnt", b_cnt, 3);
    chk("b_f1_err", b_err, 0);

    // Mode latched from first word only: 01(odd),01,00(last) -> 1
    b_word(8'h01, 1'b0, 1'b1);
    chk("b_f2_drop", b_ovalid, 0);
    b_word(8'h01, 1'b0, 1'b0);
    b_word(8'h00, 1'b1, 1'b0);
    chk("b_mode_par", b_par, 1);
    chk("b_mode_cnt", b_cnt, 3);

    // Back-to-back single-word frames, no bubble
    b_word(8'h07, 1'b1, 1'b0);
    chk("b_bb1_ovalid", b_ovalid, 1);
    chk("b_bb1_par", b_par, 1);
    chk("b_bb1_cnt", b_cnt, 1);
    b_word(8'h01, 1'b1, 1'b1);
    chk("b_bb2_ovalid", b_ovalid, 1);
    chk("b_bb2_par", b_par, 0);
    b_valid = 1'b0;
    tick();
    chk("b_drain", b_ovalid, 0);

    // Overflow at MAX_WORDS=4 with sink stalled
    c_oready = 1'b0;
    for (int i = 0; i < 4; i++) c_word(8'h01, 1'b0, 1'b0);
    chk("c_ovf_ovalid", c_ovalid, 1);
    chk("c_ovf_par", c_par, 0);
    chk("c_ovf_cnt", c_cnt, 4);
    chk("c_ovf_err", c_err, 1);

    // Back-pressure: next closing word presented but blocked for 5 cycles
    c_valid = 1'b1; c_data = 8'h01; c_last = 1'b1; c_odd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("c_bp_ready[%0d]", i), c_ready, 0);
      tick();
      chk($sformatf("c_bp_ovalid[%0d]", i), c_ovalid, 1);
      chk($sformatf("c_bp_cnt[%0d]", i), c_cnt, 4);
      chk($sformatf("c_bp_err[%0d]", i), c_err, 1);
    end
    c_oready = 1'b1;
    #1;
    chk("c_release_ready", c_ready, 1);
    tick();
    chk("c_release_ovalid", c_ovalid, 1);
    chk("c_release_par", c_par, 0);
    chk("c_release_cnt", c_cnt, 1);
    chk("c_release_err", c_err, 0);

    // Reset mid-frame discards the open accumulation
    c_word(8'h01, 1'b0, 1'b1);
    c_word(8'h00, 1'b0, 1'b1);
    c_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("c_midrst_ovalid", c_ovalid, 0);
    chk("c_midrst_ready", c_ready, 0);
    rst = 1'b0;
    #1;
    chk("c_midrst_ready_after", c_ready, 1);
    c_word(8'h00, 1'b1, 1'b0);
    chk("c_fresh_ovalid", c_ovalid, 1);
    chk("c_fresh_par", c_par, 0);
    chk("c_fresh_cnt", c_cnt, 1);
    chk("c_fresh_err", c_err, 0);
    c_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_stream.md
# parity_stream

Parametrised, clocked successor to the team's 3-input combinational parity cell. It accumulates even or odd parity across a multi-word frame arriving on a valid/ready stream, then emits one registered result per frame: parity bit, word count and overflow flag. It sits between a framed data source and a downstream checker or serializer that appends the parity bit.

## Interface
- WIDTH, default 8: data word width in bits; legal range 1 or more. WIDTH=3 with 1-word frames reproduces the original 3-input cell.
- MAX_WORDS, default 16: maximum words per frame; legal range 1 or more.
- CNT_W, derived as clog2(MAX_WORDS+1): width of the word counter and out_count.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: source presents a word.
- in_ready, output, 1: block can accept a word.
- in_data, input, WIDTH: data word.
- in_last, input, 1: the word is the final word of its frame.
- in_odd, input, 1: parity mode, 0 = even, 1 = odd. Sampled only on the first word of a frame.
- out_valid, output, 1: a frame result is held.
- out_ready, input, 1: sink accepts the result.
- out_parity, output, 1: parity bit for the frame.
- out_count, output, CNT_W: number of words in the frame, 1..MAX_WORDS.
- out_err, output, 1: frame was force-closed at MAX_WORDS without in_last.

## Operation
- Accept happens when in_valid && in_ready. Emit happens when out_valid && out_ready.
- in_ready = !rst && (!out_valid || out_ready). This is combinational and allows an accept in the same cycle as an emit.
- Frame FSM states:
  - IDLE: no frame open. acc=0, cnt=0.
  - ACCUM: frame open.
- First accept in IDLE:
  - mode_q <= in_odd.
  - acc <= ^in_data.
  - cnt <= 1.
  - Go to ACCUM, unless the word also closes the frame.
- Accept in ACCUM:
  - acc <= acc ^ (^in_data).
  - cnt <= cnt+1.
  - in_odd is ignored.
- Frame close: an accepted word with in_last=1, or an accepted word that makes cnt equal MAX_WORDS. On close:
  - out_parity <= final_acc ^ mode.
  - out_count <= final cnt.
  - out_err <= !in_last.
  - out_valid <= 1.
  - FSM returns to IDLE.
- Parity rule: even mode makes the total ones count (data plus parity bit) even, so the bit is the XOR reduction. Odd mode inverts it.
- When MAX_WORDS=1, every word closes a frame. out_err stays 0 if in_last=1, and is 1 otherwise.
- Result registers hold unchanged while out_valid && !out_ready.
- Emit without a simultaneous close: out_valid <= 0.
- Emit with a simultaneous close: the new result loads and out_valid stays 1. There is no bubble.
- Close cannot occur while out_valid && !out_ready, because in_ready is 0 then.

## Timing
- Reset values:
  - out_valid = 0, out_parity = 0, out_count = 0, out_err = 0.
  - in_ready = 0 while rst is high.
  - FSM = IDLE, acc = 0, cnt = 0, mode_q = 0.
- Reset mid-frame or with a result pending discards everything. in_ready is 1 on the first cycle after rst deasserts.
- Latency: out_valid rises on the clock edge that accepts the closing word, so the result is visible the next cycle.
- Throughput: one word per cycle, sustained across frame boundaries, provided out_ready is high whenever out_valid is high.
- Back-pressure: with out_valid=1 and out_ready=0, in_ready=0 and the open frame stalls with no state change.
- in_data, in_last and in_odd are don't-care when not accepted.

## Structure
- Shared package parity_pkg holds:
  - The FSM state enum (ST_IDLE, ST_ACCUM).
  - The parity mode constants (PAR_EVEN=0, PAR_ODD=1).
  - A clog2-based count-width function, also used by testbenches.
- One sub-module, parity_reduce: purely combinational, parameter WIDTH, input WIDTH-bit word, 1-bit XOR-reduction output. It replaces the old 3-input cell and is instantiated once.

## Test plan
- WIDTH=3, MAX_WORDS=1, even mode: sweep in_data 000..111 with in_last=1 and out_ready=1. Required out_parity sequence is 0,1,1,0,1,0,0,1 with out_count=1 and out_err=0 each time; the odd-mode sweep gives the inverted sequence.
- WIDTH=8, MAX_WORDS=16, even mode: frame 8'hFF, 8'h01, 8'h03(last) → out_parity=1, out_count=3, out_err=0, one cycle after the last accept.
- Overflow with MAX_WORDS=4: send 4 words of 8'h01, in_last=0, even mode → out_parity=0, out_count=4, out_err=1. The next word starts a new frame.
- Back-pressure: hold out_ready=0 for 5 cycles after a close → result stable and in_ready=0 for those 5 cycles. When out_ready rises, a closing 1-word frame 8'h01 (odd mode) is accepted that cycle and out_valid stays 1 with out_parity=0.
- Mode latch: first word in_odd=1, later words in_odd=0 → the frame uses odd parity.
- Reset mid-frame: after 2 accepted words, pulse rst for 1 cycle, then send 1-word frame 8'h00 (even mode) → out_parity=0, out_count=1, and no leftover accumulation.
